servo_pwm_generator: RTL and testbench

Downstream stage of the angle-to-pulse-width converter. It consumes the five 12-bit pulse-width words (microseconds), clamps each to a safe servo range and drives five standard servo PWM outputs. All five outputs share a common repeating frame (default 20 ms). Widths are double-buffered so that an output never changes its pulse width in the middle of a frame.

---
 rtl/servo_pwm_generator.sv | 155 +++++++++++++++
 tb/tb_servo_pwm_generator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_generator.sv
// Five-channel servo PWM generator. Requested widths are clamped, latched once per frame
// and driven as pulses that start together with each frame.
module servo_pwm_generator #(
   parameter int CLKS_PER_US  = 50,
   parameter int FRAME_US     = 20000,
   parameter int MIN_PULSE_US = 500,
   parameter int MAX_PULSE_US = 2500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [11:0] servo1_pwm,
   input  logic [11:0] servo2_pwm,
   input  logic [11:0] servo3_pwm,
   input  logic [11:0] servo4_pwm,
   input  logic [11:0] servo5_pwm,
   output logic        servo1_out,
   output logic        servo2_out,
   output logic        servo3_out,
   output logic        servo4_out,
   output logic        servo5_out,
   output logic        frame_start,
   output logic [4:0]  clamp_flags,
   output logic        running
);

   localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam int FW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam int CW = (FW > 12) ? FW : 12;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_US - 1);
   localparam logic [11:0]   MIN_W      = 12'(MIN_PULSE_US);
   localparam logic [11:0]   MAX_W      = 12'(MAX_PULSE_US);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [11:0]   shadow_q [5];
   logic [11:0]   shadow_d [5];
   logic [4:0]    clamp_q, clamp_d;
   logic [4:0]    out_q, out_d;
   logic          fs_q, fs_d;

   logic [11:0] pwm_in  [5];
   logic [11:0] clamped [5];
   logic [4:0]  clamp_hit;
   logic        tick, frame_end, load;

   assign pwm_in[0] = servo1_pwm;
   assign pwm_in[1] = servo2_pwm;
   assign pwm_in[2] = servo3_pwm;
   assign pwm_in[3] = servo4_pwm;
   assign pwm_in[4] = servo5_pwm;

   assign tick      = (presc_q == PRESC_LAST);
   assign frame_end = tick && (frame_q == FRAME_LAST);

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         clamped[i]   = pwm_in[i];
         clamp_hit[i] = 1'b0;
         if (pwm_in[i] < MIN_W) begin
            clamped[i]   = MIN_W;
            clamp_hit[i] = 1'b1;
         end else if (pwm_in[i] > MAX_W) begin
            clamped[i]   = MAX_W;
            clamp_hit[i] = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d  = state_q;
      presc_d  = presc_q;
      frame_d  = frame_q;
      shadow_d = shadow_q;
      clamp_d  = clamp_q;
      fs_d     = 1'b0;
      load     = 1'b0;
      out_d    = '0;

      case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            frame_d = '0;
            load    = enable;
         end
         default: begin
            if (tick) begin
               presc_d = '0;
               frame_d = frame_q + FW'(1);
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if (frame_end) begin
               load = enable;
               if (!enable) begin
                  state_d = ST_IDLE;
                  frame_d = '0;
               end
            end
         end
      endcase

      if (load) begin
         state_d  = ST_RUN;
         presc_d  = '0;
         frame_d  = '0;
         shadow_d = clamped;
         clamp_d  = clamp_hit;
         fs_d     = 1'b1;
      end

      // Outputs are registered from next-state so each pulse rises with frame_start.
      for (int i = 0; i < 5; i++) begin
         out_d[i] = (state_d == ST_RUN) && (CW'(frame_d) < CW'(shadow_d[i]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         frame_q <= '0;
         // NOTE: the shadow array is reset as well; it is only five words and keeps restart deterministic.
         for (int i = 0; i < 5; i++) shadow_q[i] <= '0;
         clamp_q <= '0;
         out_q   <= '0;
         fs_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         frame_q  <= frame_d;
         shadow_q <= shadow_d;
         clamp_q  <= clamp_d;
         out_q    <= out_d;
         fs_q     <= fs_d;
      end
   end

   assign servo1_out  = out_q[0];
   assign servo2_out  = out_q[1];
   assign servo3_out  = out_q[2];
   assign servo4_out  = out_q[3];
   assign servo5_out  = out_q[4];
   assign frame_start = fs_q;
   assign clamp_flags = clamp_q;
   assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Bench for servo_pwm_generator: directed and random frames measured against a
// frame-level model (clamped widths, frame length, flags).
module tb_servo_pwm_generator;

   localparam int CLKS       = 1;
   localparam int FRAME      = 4000;
   localparam int MINP       = 500;
   localparam int MAXP       = 2500;
   localparam int FRAME_CLKS = CLKS * FRAME;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [11:0] pwm [5];
   logic        servo1_out, servo2_out, servo3_out, servo4_out, servo5_out;
   logic        frame_start, running;
   logic [4:0]  clamp_flags;
   logic [4:0]  outs;

   int n_checks = 0;
   int n_fails  = 0;

   int         exp_w [5];
   int         nxt_w [5];
   logic [4:0] exp_flags, nxt_flags;

   servo_pwm_generator #(
      .CLKS_PER_US (CLKS),
      .FRAME_US    (FRAME),
      .MIN_PULSE_US(MINP),
      .MAX_PULSE_US(MAXP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .servo1_pwm (pwm[0]),
      .servo2_pwm (pwm[1]),
      .servo3_pwm (pwm[2]),
      .servo4_pwm (pwm[3]),
      .servo5_pwm (pwm[4]),
      .servo1_out (servo1_out),
      .servo2_out (servo2_out),
      .servo3_out (servo3_out),
      .servo4_out (servo4_out),
      .servo5_out (servo5_out),
      .frame_start(frame_start),
      .clamp_flags(clamp_flags),
      .running    (running)
   );

   assign outs = {servo5_out, servo4_out, servo3_out, servo2_out, servo1_out};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int clampw(input int v);
      if (v < MINP) return MINP;
      if (v > MAXP) return MAXP;
      return v;
   endfunction

   // Model of a frame load: what the DUT latched from the inputs at the last load edge.
   task automatic snapshot();
      for (int i = 0; i < 5; i++) begin
         nxt_w[i]     = clampw(int'(pwm[i]));
         nxt_flags[i] = (int'(pwm[i]) < MINP) || (int'(pwm[i]) > MAXP);
      end
   endtask

   task automatic wait_fs(input int bound, input string tag);
      int c = 0;
      while (!frame_start && c < bound) begin
         @(negedge clk);
         c++;
      end
      check(tag, {31'b0, frame_start}, 32'd1);
      snapshot();
   endtask

   // Entered on the negedge where frame_start is high; leaves on the next one.
   task automatic run_frame(input string tag, input int upd_cyc, input logic [11:0] upd_val,
                            input int drop_cyc);
      int         hi [5];
      bit         fell [5];
      logic [4:0] glitch;
      logic [4:0] rise_exp;
      int         c;
      int         bound;
      bit         done;
      exp_w     = nxt_w;
      exp_flags = nxt_flags;
      glitch    = '0;
      for (int i = 0; i < 5; i++) begin
         hi[i]       = 0;
         fell[i]     = 1'b0;
         rise_exp[i] = (exp_w[i] > 0);
      end
      check({tag, ".flags"}, {27'b0, clamp_flags}, {27'b0, exp_flags});
      check({tag, ".rise"}, {27'b0, outs}, {27'b0, rise_exp});
      check({tag, ".running"}, {31'b0, running}, 32'd1);
      bound = (drop_cyc >= 0) ? FRAME_CLKS + 50 : 2 * FRAME_CLKS;
      c     = 0;
      done  = 1'b0;
      while (!done) begin
         for (int i = 0; i < 5; i++) begin
            if (outs[i]) begin
               if (fell[i]) glitch[i] = 1'b1;
               hi[i]++;
            end else begin
               fell[i] = 1'b1;
            end
         end
         if (drop_cyc >= 0 && c == FRAME_CLKS - 1)
            check({tag, ".run_last"}, {31'b0, running}, 32'd1);
         if (drop_cyc >= 0 && c == FRAME_CLKS)
            check({tag, ".idle_after"}, {26'b0, outs, running}, 32'd0);
         if (c == upd_cyc) pwm[0] = upd_val;
         if (c == drop_cyc) enable = 1'b0;
         @(negedge clk);
         c++;
         if (frame_start || c >= bound) done = 1'b1;
      end
      if (drop_cyc >= 0) begin
         check({tag, ".no_fs"}, {31'b0, frame_start}, 32'd0);
      end else begin
         check({tag, ".len"}, c, FRAME_CLKS);
      end
      for (int i = 0; i < 5; i++)
         check($sformatf("%s.width%0d", tag, i + 1), hi[i], exp_w[i] * CLKS);
      check({tag, ".contig"}, {27'b0, glitch}, 32'd0);
      if (frame_start) snapshot();
   endtask

   initial begin
      for (int i = 0; i < 5; i++) pwm[i] = 12'd1234;
      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", {24'b0, outs, frame_start, running, clamp_flags}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         check("idle", {24'b0, outs, frame_start, running, clamp_flags}, 32'd0);
      end

      // Nominal run
      pwm[0] = 12'd1500; pwm[1] = 12'd500; pwm[2] = 12'd1000; pwm[3] = 12'd2000; pwm[4] = 12'd2500;
      enable = 1'b1;
      wait_fs(1, "nom.start");
      check("nom.flags0", {27'b0, clamp_flags}, 32'd0);
      run_frame("nom1", -1, 12'd0, -1);
      run_frame("nom2", -1, 12'd0, -1);

      // Clamping: new inputs take effect one frame later
      pwm[2] = 12'd3305; pwm[3] = 12'd100; pwm[4] = 12'd0;
      run_frame("pre_clamp", -1, 12'd0, -1);
      check("clamp.flags_const", {27'b0, clamp_flags}, {27'b0, 5'b11100});
      pwm[0] = 12'd1000;
      run_frame("clamp", -1, 12'd0, -1);

      // Mid-frame update has no effect until the next load
      run_frame("mid", 300, 12'd2000, -1);
      run_frame("after_mid", -1, 12'd0, -1);

      // Random frames
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) pwm[i] = 12'($urandom_range(0, 4095));
         run_frame($sformatf("rand%0d", r), int'($urandom_range(1, 3990)),
                   12'($urandom_range(0, 4095)), -1);
      end

      // Async reset mid-pulse
      pwm[0] = 12'd1500; pwm[1] = 12'd500; pwm[2] = 12'd1000; pwm[3] = 12'd2000; pwm[4] = 12'd2500;
      run_frame("pre_rst", -1, 12'd0, -1);
      repeat (700) @(negedge clk);
      check("rst.pulse_high", {31'b0, servo1_out}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst.async", {24'b0, outs, frame_start, running, clamp_flags}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_fs(1, "rst.restart");

      // Enable drop mid-frame: frame completes, then idle
      run_frame("drop", -1, 12'd0, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
